// File: rtl/grf_scan.sv
// grf_scan: streams a contiguous range of general register file (GRF)
// entries out over a valid/ready interface so a debugger can dump them.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-low reset (0 = held in reset)
//   start      one-cycle dump request, only looked at while idle
//   first_idx  first register of the dump, captured with start
//   last_idx   final register of the dump, captured with start
//   abort      cancels a dump in progress, no done pulse follows
//   rd_addr    GRF read address, data comes back the same cycle
//   rd_data    GRF read data for rd_addr
//   out_valid  stream beat valid
//   out_ready  consumer accepts the beat
//   out_idx    register index carried by the beat
//   out_data   register value carried by the beat
//   out_last   beat is the final one of the dump
//   stall_req  asks the pipeline to freeze the GRF while a dump runs
//   done       one-cycle pulse when a dump finishes normally
module grf_scan #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic          stall_req,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] EMPTY = 2'd3;

  localparam logic [AW-1:0] MAX_IDX = AW'(NREG - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_r;
  logic [AW-1:0] last_clamped;
  logic          load;

  // A request reaching past the end of the register file is trimmed to
  // the last real register so the scan never addresses missing entries.
  assign last_clamped = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;

  // A new beat is captured whenever the output register is empty or is
  // being emptied this cycle; abort wins over any capture.
  assign load = (state == RUN) && (!out_valid || out_ready) && !abort;

  assign rd_addr   = (state == RUN) ? idx : '0;
  assign stall_req = (state == RUN) || (state == DRAIN);

  // Main sequencer. The beat holding idx==last moves to DRAIN without
  // advancing idx, so a dump ending at the top register cannot wrap
  // back to zero and produce extra beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      last_r    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (last_clamped >= first_idx) begin
                idx    <= first_idx;
                last_r <= last_clamped;
                state  <= RUN;
              end else begin
                state <= EMPTY;
              end
            end
          end
          RUN: begin
            if (load) begin
              // Register $0 is hardwired to zero whatever the GRF returns.
              out_data  <= (idx == '0) ? 32'd0 : rd_data;
              out_idx   <= idx;
              out_last  <= (idx == last_r);
              out_valid <= 1'b1;
              if (idx == last_r) begin
                state <= DRAIN;
              end else begin
                idx <= idx + AW'(1);
              end
            end
          end
          DRAIN: begin
            if (!out_valid || out_ready) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
          EMPTY: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grf_scan.sv
// tb_grf_scan: directed bench for grf_scan with a queue-based scoreboard.
// Tests push the beats they expect; a monitor on the falling edge pops
// and compares every accepted beat, and tracks done pulses and timing.
module tb_grf_scan;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        stall_req;
  logic        done;
  logic        grf_bad0;

  beat_t exp_q[$];
  int    hs_q[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    last_beat_cyc = -1;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  grf_scan #(.NREG(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .first_idx(first_idx),
    .last_idx(last_idx), .abort(abort), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .stall_req(stall_req), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // GRF model: reg[i] = i*0x11; optionally returns junk for $0 so the
  // hardwired-zero behaviour is actually exercised.
  assign rd_data = (grf_bad0 && rd_addr == 5'd0) ? 32'hDEADBEEF
                                                 : 32'(rd_addr) * 32'h11;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pushBeat(input int i);
    beat_t b;
    b.idx  = 5'(i);
    b.data = (i == 0) ? 32'd0 : 32'(i) * 32'h11;
    b.last = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic markLast();
    beat_t b;
    b = exp_q[exp_q.size()-1];
    b.last = 1'b1;
    exp_q[exp_q.size()-1] = b;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: sampled mid-cycle so the values seen are what the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) checkOutput("stall_while_valid", stall_req, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_beat: got idx %0d data 0x%0h, required no beat",
                   out_idx, out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("beat_idx", out_idx, e.idx);
          checkOutput("beat_data", out_data, e.data);
          checkOutput("beat_last", out_last, e.last);
        end
        hs_q.push_back(cyc);
        if (out_last) last_beat_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_idx = '0; last_idx = '0; grf_bad0 = 1'b0;

    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_stall", stall_req, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] full dump 0..31");
    hs_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) pushBeat(i);
    markLast();
    applyStimulus(5'd0, 5'd31);
    checkOutput("run_stall", stall_req, 1);
    waitDrain(200);
    checkOutput("full_beats", hs_q.size(), 32);
    if (hs_q.size() == 32) checkOutput("full_consecutive", hs_q[31] - hs_q[0], 31);
    checkOutput("full_done_cnt", done_cnt - d0, 1);
    checkOutput("full_done_timing", done_cyc, last_beat_cyc + 1);
    checkOutput("full_idle_stall", stall_req, 0);

    $display("[TB] backpressure 3..5");
    hs_q.delete();
    out_ready = 1'b0;
    for (int i = 3; i <= 5; i++) pushBeat(i);
    markLast();
    applyStimulus(5'd3, 5'd5);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_idx", out_idx, 3);
      checkOutput("stall_data", out_data, 32'h33);
    end
    out_ready = 1'b1;
    waitDrain(50);
    checkOutput("bp_beats", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      checkOutput("bp_b2b_1", hs_q[1] - hs_q[0], 1);
      checkOutput("bp_b2b_2", hs_q[2] - hs_q[1], 1);
    end

    $display("[TB] empty range 7..2");
    hs_q.delete();
    d0 = done_cnt;
    applyStimulus(5'd7, 5'd2);
    checkOutput("empty_stall", stall_req, 0);
    checkOutput("empty_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("empty_done_pulse", done, 1);
    checkOutput("empty_stall2", stall_req, 0);
    @(posedge clk); #1;
    checkOutput("empty_done_clear", done, 0);
    checkOutput("empty_done_cnt", done_cnt - d0, 1);
    checkOutput("empty_beats", hs_q.size(), 0);

    $display("[TB] abort on third beat");
    hs_q.delete();
    d0 = done_cnt;
    pushBeat(0); pushBeat(1);
    applyStimulus(5'd0, 5'd31);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abort_pre_idx", out_idx, 2);
    abort = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_stall", stall_req, 0);
    checkOutput("abort_rd_addr", rd_addr, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b1;
    grf_bad0 = 1'b1;
    pushBeat(0); pushBeat(1);
    markLast();
    applyStimulus(5'd0, 5'd1);
    waitDrain(50);
    grf_bad0 = 1'b0;
    checkOutput("restart_done", done_cnt - d0, 1);

    $display("[TB] reset mid-run");
    hs_q.delete();
    d0 = done_cnt;
    applyStimulus(5'd0, 5'd31);
    @(posedge clk); #1;
    checkOutput("prereset_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_valid", out_valid, 0);
    checkOutput("async_idx", out_idx, 0);
    checkOutput("async_data", out_data, 0);
    checkOutput("async_last", out_last, 0);
    checkOutput("async_stall", stall_req, 0);
    checkOutput("async_rd_addr", rd_addr, 0);
    checkOutput("async_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("post_reset_beats", hs_q.size(), 0);
    checkOutput("post_reset_done", done_cnt - d0, 0);

    $display("[TB] single beat 31..31");
    hs_q.delete();
    d0 = done_cnt;
    pushBeat(31);
    markLast();
    applyStimulus(5'd31, 5'd31);
    waitDrain(50);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("top_beats", hs_q.size(), 1);
    checkOutput("top_done", done_cnt - d0, 1);
    checkOutput("top_valid", out_valid, 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
